// File: rtl/vx_iter_div_unit.sv
// Multi-lane iterative integer divider: one restoring radix-2 step per cycle on all lanes,
// with early-out when no active lane needs the long division.
module vx_iter_div_unit #(
  parameter int XLEN      = 32,
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_is_signed,
  input  logic                      in_is_rem,
  input  logic                      in_is_w,
  input  logic [NUM_LANES-1:0]      in_tmask,
  input  logic [NUM_LANES*XLEN-1:0] in_numer,
  input  logic [NUM_LANES*XLEN-1:0] in_denom,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANES-1:0]      out_tmask,
  output logic [NUM_LANES*XLEN-1:0] out_result,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      busy
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_next;
  logic                 w_fire;
  logic                 w_is_w;
  logic [XLEN-1:0]      w_int_min;
  logic [NUM_LANES-1:0] w_lane_normal;

  logic                 r_is_rem;
  logic                 r_is_w;
  logic [NUM_LANES-1:0] r_tmask;
  logic [TAG_WIDTH-1:0] r_tag;

  assign w_is_w    = (XLEN == 64) && in_is_w;
  // Most-negative value of the effective operand width, as seen after extension
  assign w_int_min = w_is_w ? ({XLEN{1'b1}} << 31) : ({XLEN{1'b1}} << (XLEN - 1));

  assign in_ready  = (r_state == S_IDLE);
  assign w_fire    = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_tmask = r_tmask;
  assign out_tag   = r_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_count_next = w_is_w ? CNT_W'(32) : CNT_W'(XLEN);
          w_state_next = (|w_lane_normal) ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        w_count_next = r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_is_rem <= in_is_rem;
      r_is_w   <= w_is_w;
      r_tmask  <= in_tmask;
      r_tag    <= in_tag;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [XLEN-1:0] w_numer_raw;
    logic [XLEN-1:0] w_denom_raw;
    logic [XLEN-1:0] w_numer_ext;
    logic [XLEN-1:0] w_denom_ext;
    logic [XLEN-1:0] w_numer_mag;
    logic [XLEN-1:0] w_denom_mag;
    logic [XLEN-1:0] w_q_init;
    logic            w_numer_neg;
    logic            w_denom_neg;
    logic            w_dbz;
    logic            w_ovf;

    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_r;
    logic [XLEN-1:0] r_d;
    logic [XLEN-1:0] r_numer;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_dbz;
    logic            r_ovf;

    logic [XLEN:0]   w_rem_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_raw;
    logic [XLEN-1:0] w_signed_res;
    logic [XLEN-1:0] w_pick;
    logic [XLEN-1:0] w_final;

    assign w_numer_raw = in_numer[gi*XLEN +: XLEN];
    assign w_denom_raw = in_denom[gi*XLEN +: XLEN];

    assign w_numer_ext = !w_is_w     ? w_numer_raw :
                         in_is_signed ? XLEN'($signed(w_numer_raw[31:0])) :
                                        XLEN'(w_numer_raw[31:0]);
    assign w_denom_ext = !w_is_w     ? w_denom_raw :
                         in_is_signed ? XLEN'($signed(w_denom_raw[31:0])) :
                                        XLEN'(w_denom_raw[31:0]);

    assign w_numer_neg = in_is_signed & w_numer_ext[XLEN-1];
    assign w_denom_neg = in_is_signed & w_denom_ext[XLEN-1];
    assign w_numer_mag = w_numer_neg ? -w_numer_ext : w_numer_ext;
    assign w_denom_mag = w_denom_neg ? -w_denom_ext : w_denom_ext;
    // W-mode dividend is parked in the top half so only 32 steps are needed
    assign w_q_init    = w_is_w ? (w_numer_mag << (XLEN - 32)) : w_numer_mag;

    assign w_dbz = (w_denom_ext == '0);
    assign w_ovf = in_is_signed && (w_numer_ext == w_int_min) && (w_denom_ext == '1);
    assign w_lane_normal[gi] = in_tmask[gi] && !w_dbz && !w_ovf;

    assign w_rem_shift = {r_r, r_q[XLEN-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_d};
    assign w_ge        = ~w_diff[XLEN];

    always_ff @(posedge clk) begin
      if (w_fire) begin
        r_q     <= w_q_init;
        r_r     <= '0;
        r_d     <= w_denom_mag;
        r_numer <= w_numer_ext;
        r_neg_q <= w_numer_neg ^ w_denom_neg;
        r_neg_r <= w_numer_neg;
        r_dbz   <= w_dbz;
        r_ovf   <= w_ovf;
      end else if (r_state == S_BUSY) begin
        r_q <= {r_q[XLEN-2:0], w_ge};
        r_r <= w_ge ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
      end
    end

    assign w_raw        = r_is_rem ? r_r : r_q;
    assign w_signed_res = (r_is_rem ? r_neg_r : r_neg_q) ? -w_raw : w_raw;
    assign w_pick       = r_dbz ? (r_is_rem ? r_numer : '1) :
                          r_ovf ? (r_is_rem ? '0 : r_numer) :
                                  w_signed_res;
    assign w_final      = r_is_w ? XLEN'($signed(w_pick[31:0])) : w_pick;

    assign out_result[gi*XLEN +: XLEN] = r_tmask[gi] ? w_final : '0;
  end

endmodule

// File: tb/tb_vx_iter_div_unit.sv
// Directed/random bench for vx_iter_div_unit: a 32-bit and a 64-bit instance share one clock.
module tb_vx_iter_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst32_n, rst64_n;
  logic         d32_valid, d32_rdy, d32_sgn, d32_rem, d32_w, d32_ov, d32_ordy, d32_busy;
  logic [3:0]   d32_tm, d32_otm;
  logic [127:0] d32_numer, d32_denom, d32_res;
  logic [7:0]   d32_tag, d32_otag;
  logic         d64_valid, d64_rdy, d64_sgn, d64_rem, d64_w, d64_ov, d64_ordy, d64_busy;
  logic [3:0]   d64_tm, d64_otm;
  logic [255:0] d64_numer, d64_denom, d64_res;
  logic [7:0]   d64_tag, d64_otag;

  vx_iter_div_unit #(.XLEN(32), .NUM_LANES(4), .TAG_WIDTH(8)) u_dut32 (
    .clk(clk), .reset_n(rst32_n), .in_valid(d32_valid), .in_ready(d32_rdy),
    .in_is_signed(d32_sgn), .in_is_rem(d32_rem), .in_is_w(d32_w), .in_tmask(d32_tm),
    .in_numer(d32_numer), .in_denom(d32_denom), .in_tag(d32_tag), .out_tag(d32_otag),
    .out_valid(d32_ov), .out_ready(d32_ordy), .out_tmask(d32_otm), .out_result(d32_res),
    .busy(d32_busy)
  );

  vx_iter_div_unit #(.XLEN(64), .NUM_LANES(4), .TAG_WIDTH(8)) u_dut64 (
    .clk(clk), .reset_n(rst64_n), .in_valid(d64_valid), .in_ready(d64_rdy),
    .in_is_signed(d64_sgn), .in_is_rem(d64_rem), .in_is_w(d64_w), .in_tmask(d64_tm),
    .in_numer(d64_numer), .in_denom(d64_denom), .in_tag(d64_tag), .out_tag(d64_otag),
    .out_valid(d64_ov), .out_ready(d64_ordy), .out_tmask(d64_otm), .out_result(d64_res),
    .busy(d64_busy)
  );

  typedef struct packed {
    logic [3:0][63:0] res;
    logic [3:0]       tm;
    logic [7:0]       tag;
  } exp_t;

  exp_t        scb[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  tag_cnt = 8'h10;
  logic [63:0] a_l[4];
  logic [63:0] b_l[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics computed with native operators
  function automatic logic [63:0] model(input bit wide, input bit w, input bit sgn,
                                        input bit rem, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic signed [31:0] sa, sb, sr;
    logic [63:0] r64;
    logic signed [63:0] sa64, sb64, sr64;
    if (!wide || w) begin
      a32 = a[31:0]; b32 = b[31:0]; sa = a32; sb = b32;
      if (b32 == 32'd0) r32 = rem ? a32 : 32'hFFFF_FFFF;
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'd0 : a32;
      else if (sgn) begin sr = rem ? sa % sb : sa / sb; r32 = sr; end
      else r32 = rem ? a32 % b32 : a32 / b32;
      return wide ? {{32{r32[31]}}, r32} : {32'd0, r32};
    end
    sa64 = a; sb64 = b;
    if (b == 64'd0) r64 = rem ? a : '1;
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) r64 = rem ? 64'd0 : a;
    else if (sgn) begin sr64 = rem ? sa64 % sb64 : sa64 / sb64; r64 = sr64; end
    else r64 = rem ? a % b : a / b;
    return r64;
  endfunction

  function automatic logic rdy(input bit wide);   return wide ? d64_rdy : d32_rdy;   endfunction
  function automatic logic ov(input bit wide);    return wide ? d64_ov : d32_ov;     endfunction
  function automatic logic bsy(input bit wide);   return wide ? d64_busy : d32_busy; endfunction
  function automatic logic [3:0] otm(input bit wide); return wide ? d64_otm : d32_otm; endfunction
  function automatic logic [7:0] otag(input bit wide); return wide ? d64_otag : d32_otag; endfunction
  function automatic logic [63:0] res(input bit wide, input int i);
    return wide ? d64_res[i*64 +: 64] : {32'd0, d32_res[i*32 +: 32]};
  endfunction

  task automatic drive(input bit wide, input bit w, input bit sgn, input bit rem,
                       input logic [3:0] tm, input logic [7:0] tg);
    if (wide) begin
      d64_valid = 1'b1; d64_w = w; d64_sgn = sgn; d64_rem = rem; d64_tm = tm; d64_tag = tg;
      for (int i = 0; i < 4; i++) begin
        d64_numer[i*64 +: 64] = a_l[i];
        d64_denom[i*64 +: 64] = b_l[i];
      end
    end else begin
      d32_valid = 1'b1; d32_w = 1'b0; d32_sgn = sgn; d32_rem = rem; d32_tm = tm; d32_tag = tg;
      for (int i = 0; i < 4; i++) begin
        d32_numer[i*32 +: 32] = a_l[i][31:0];
        d32_denom[i*32 +: 32] = b_l[i][31:0];
      end
    end
  endtask

  // Garbage request held valid while the unit must not accept it
  task automatic scramble(input bit wide);
    if (wide) begin
      d64_valid = 1'b1; d64_sgn = 1'($urandom); d64_rem = 1'($urandom);
      d64_w = 1'($urandom); d64_tm = 4'($urandom); d64_tag = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
        d64_numer[i*64 +: 64] = {$urandom, $urandom};
        d64_denom[i*64 +: 64] = {$urandom, $urandom};
      end
    end else begin
      d32_valid = 1'b1; d32_sgn = 1'($urandom); d32_rem = 1'($urandom);
      d32_w = 1'($urandom); d32_tm = 4'($urandom); d32_tag = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
        d32_numer[i*32 +: 32] = $urandom;
        d32_denom[i*32 +: 32] = $urandom;
      end
    end
  endtask

  task automatic drop_valid(input bit wide);
    if (wide) d64_valid = 1'b0; else d32_valid = 1'b0;
  endtask

  task automatic set_ready(input bit wide, input logic v);
    if (wide) d64_ordy = v; else d32_ordy = v;
  endtask

  task automatic set_all(input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < 4; i++) begin a_l[i] = a; b_l[i] = b; end
  endtask

  task automatic run_op(input bit wide, input bit w, input bit sgn, input bit rem,
                        input logic [3:0] tm, input int exp_lat, input int stall, input string name);
    exp_t e;
    int n;
    logic [7:0] tg;
    tg = tag_cnt;
    tag_cnt++;
    for (int i = 0; i < 4; i++) e.res[i] = tm[i] ? model(wide, w, sgn, rem, a_l[i], b_l[i]) : 64'd0;
    e.tm = tm;
    e.tag = tg;
    scb.push_back(e);
    @(negedge clk);
    chk({name, ":in_ready_idle"}, 64'(rdy(wide)), 64'd1);
    drive(wide, w, sgn, rem, tm, tg);
    @(posedge clk);
    #1;
    scramble(wide);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk({name, ":busy"}, 64'(bsy(wide)), 64'd1);
      if (n == 4) drop_valid(wide);
    end while (!ov(wide) && n < 200);
    drop_valid(wide);
    chk({name, ":latency"}, 64'(n), 64'(exp_lat));
    e = scb.pop_front();
    for (int k = 0; k < stall; k++) begin
      chk({name, ":stall_res"}, {d64_res[63:0] ^ 64'(wide ? 64'd0 : 64'd0), 64'd0} == 128'd0 ? 64'd0 : 64'd0, 64'd0);
      chk({name, ":stall_lane0"}, res(wide, 0), e.res[0]);
      chk({name, ":stall_lane3"}, res(wide, 3), e.res[3]);
      chk({name, ":stall_in_ready"}, 64'(rdy(wide)), 64'd0);
      chk({name, ":stall_out_valid"}, 64'(ov(wide)), 64'd1);
      scramble(wide);
      @(negedge clk);
    end
    drop_valid(wide);
    for (int i = 0; i < 4; i++) chk($sformatf("%s:lane%0d", name, i), res(wide, i), e.res[i]);
    chk({name, ":tmask"}, 64'(otm(wide)), 64'(e.tm));
    chk({name, ":tag"}, 64'(otag(wide)), 64'(e.tag));
    set_ready(wide, 1'b1);
    @(posedge clk);
    #1;
    set_ready(wide, 1'b0);
    @(negedge clk);
    chk({name, ":in_ready_after"}, 64'(rdy(wide)), 64'd1);
    chk({name, ":out_valid_after"}, 64'(ov(wide)), 64'd0);
  endtask

  task automatic reset_mid(input bit wide, input string name);
    int seen;
    set_all(64'd100, 64'd7);
    @(negedge clk);
    drive(wide, 1'b0, 1'b0, 1'b0, 4'hF, 8'hEE);
    @(posedge clk);
    #1;
    drop_valid(wide);
    repeat (10) @(negedge clk);
    chk({name, ":busy_before_reset"}, 64'(bsy(wide)), 64'd1);
    #2;
    if (wide) rst64_n = 1'b0; else rst32_n = 1'b0;
    #1;
    chk({name, ":rst_in_ready"}, 64'(rdy(wide)), 64'd1);
    chk({name, ":rst_busy"}, 64'(bsy(wide)), 64'd0);
    chk({name, ":rst_out_valid"}, 64'(ov(wide)), 64'd0);
    @(negedge clk);
    if (wide) rst64_n = 1'b1; else rst32_n = 1'b1;
    #1;
    chk({name, ":release_in_ready"}, 64'(rdy(wide)), 64'd1);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (ov(wide)) seen++;
    end
    chk({name, ":no_output"}, 64'(seen), 64'd0);
  endtask

  initial begin
    rst32_n = 1'b0; rst64_n = 1'b0;
    d32_valid = 0; d32_sgn = 0; d32_rem = 0; d32_w = 0; d32_tm = 0; d32_tag = 0; d32_ordy = 0;
    d32_numer = '0; d32_denom = '0;
    d64_valid = 0; d64_sgn = 0; d64_rem = 0; d64_w = 0; d64_tm = 0; d64_tag = 0; d64_ordy = 0;
    d64_numer = '0; d64_denom = '0;
    #2;
    chk("reset:in_ready", 64'(d32_rdy), 64'd1);
    chk("reset:out_valid", 64'(d32_ov), 64'd0);
    chk("reset:busy", 64'(d32_busy), 64'd0);
    chk("reset64:in_ready", 64'(d64_rdy), 64'd1);
    repeat (3) @(negedge clk);
    rst32_n = 1'b1; rst64_n = 1'b1;

    set_all(64'd100, 64'd7);
    run_op(0, 0, 0, 0, 4'hF, 33, 0, "divu_100_7");
    run_op(0, 0, 0, 1, 4'hF, 33, 0, "remu_100_7");

    set_all(64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    run_op(0, 0, 1, 0, 4'b1011, 33, 0, "div_m7_2");
    run_op(0, 0, 1, 1, 4'b1011, 33, 0, "rem_m7_2");

    set_all(64'd5, 64'd0);
    run_op(0, 0, 0, 0, 4'hF, 1, 0, "divu_by0");
    run_op(0, 0, 0, 1, 4'hF, 1, 0, "remu_by0");
    a_l[2] = 64'd9; b_l[2] = 64'd3;
    run_op(0, 0, 0, 0, 4'hF, 33, 0, "by0_lane2_norm");

    set_all(64'h8000_0000, 64'hFFFF_FFFF);
    run_op(0, 0, 1, 0, 4'hF, 1, 0, "div_ovf");
    run_op(0, 0, 1, 1, 4'hF, 1, 0, "rem_ovf");

    set_all(64'd50, 64'd5);
    run_op(0, 0, 0, 0, 4'h0, 1, 0, "tmask_zero");

    a_l[0] = 64'd5;             b_l[0] = 64'd0;
    a_l[1] = 64'h8000_0000;     b_l[1] = 64'hFFFF_FFFF;
    a_l[2] = 64'hFFFF_FF9C;     b_l[2] = 64'd7;
    a_l[3] = 64'd1;             b_l[3] = 64'd1;
    run_op(0, 0, 1, 0, 4'b0111, 33, 0, "mixed_div");
    run_op(0, 0, 1, 1, 4'b0111, 33, 0, "mixed_rem");

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        a_l[i] = {32'd0, $urandom};
        b_l[i] = {32'd0, $urandom_range(1, 5000)};
      end
      b_l[1] = {32'd0, 32'hFFFF_FF00 | $urandom_range(1, 255)};
      run_op(0, 0, 1'(k & 1), 1'((k >> 1) & 1), 4'hF, 33, 0, $sformatf("rand32_%0d", k));
    end

    set_all(64'd100, 64'd7);
    run_op(0, 0, 0, 0, 4'hF, 33, 10, "stall");

    reset_mid(0, "rst32");

    set_all(64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0001);
    run_op(1, 1, 0, 0, 4'hF, 33, 0, "w_divu_ffffffff_1");
    set_all(64'h5555_0000_FFFF_FFF9, 64'h0000_0007_0000_0002);
    run_op(1, 1, 1, 1, 4'hF, 33, 0, "w_rem_m7_2");
    run_op(1, 1, 1, 0, 4'hF, 33, 0, "w_div_m7_2");
    set_all(64'd77, 64'h0000_0001_0000_0000);
    run_op(1, 1, 0, 1, 4'hF, 1, 0, "w_remu_by0");

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        a_l[i] = {$urandom, $urandom};
        b_l[i] = {32'($urandom_range(0, 15)), $urandom} | 64'd1;
      end
      run_op(1, 0, 1'(k), 1'(k), 4'hF, 65, 0, $sformatf("rand64_%0d", k));
    end

    reset_mid(1, "rst64");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_iter_div_unit.md
VX_ITER_DIV_UNIT -- requirements
Module: VX_iter_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width; legal values 32 or 64.
REQ-002 SHALL have parameter NUM_LANES, default 4, number of SIMD lanes.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, width of the opaque request tag.
REQ-004 SHALL have port clk  input  1  clock; the block uses one clock only.
REQ-005 SHALL have port reset_n  input  1  reset; reset is asynchronous and active-low.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1: the request handshake.
REQ-007 SHALL have port in_is_signed  input  1  signed (DIV/REM) versus unsigned (DIVU/REMU).
REQ-008 SHALL have port in_is_rem  input  1  return remainder (1) or quotient (0).
REQ-009 SHALL have port in_is_w  input  1  32-bit W-op; ignored when XLEN=32.
REQ-010 SHALL have port in_tmask  input  NUM_LANES  active-lane mask.
REQ-011 SHALL have ports in_numer and in_denom, input, NUM_LANES*XLEN each: per-lane dividend and divisor.
REQ-012 SHALL have ports in_tag input TAG_WIDTH and out_tag output TAG_WIDTH: the tag passes through unchanged.
REQ-013 SHALL have ports out_valid output 1 and out_ready input 1: the response handshake.
REQ-014 SHALL have ports out_tmask output NUM_LANES and out_result output NUM_LANES*XLEN.
REQ-015 SHALL have port busy  output  1: high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL, on a fire (in_valid&&in_ready), register all inputs and operand magnitudes (absolute values when signed), and set the iteration counter to 32 if in_is_w&&XLEN==64, else XLEN.
REQ-018 SHALL, in W mode, sign-extend (signed) or zero-extend (unsigned) bits [31:0] of each operand before processing.
REQ-019 SHALL classify each active lane at fire: div-by-zero (denom==0), signed overflow (signed, numer==most-negative, denom==-1), or normal.
REQ-020 SHALL move IDLE->DONE on fire when no active lane is normal, including tmask==0 (early-out, latency 1 cycle); otherwise IDLE->BUSY.
REQ-021 SHALL, in BUSY, perform one radix-2 restoring iteration per cycle on every lane in parallel, decrement the counter, and go to DONE after the iteration that brings the counter to 0: out_valid at cycle XLEN+1 (W: 33) after the fire cycle.
REQ-022 SHALL return for a div-by-zero lane: quotient all-ones, remainder = dividend.
REQ-023 SHALL return for a signed-overflow lane: quotient = dividend, remainder 0.
REQ-024 SHALL, for a normal signed lane, negate the quotient when the operand signs differ; the remainder takes the sign of the dividend.
REQ-025 SHALL, in W mode, sign-extend the 32-bit result to XLEN, for unsigned ops too (RV64 semantics).
REQ-026 SHALL drive out_result lane i to 0 when out_tmask[i]=0.
REQ-027 SHALL hold out_result, out_tmask and out_tag stable while out_valid&&!out_ready.
REQ-028 SHALL move DONE->IDLE on out_valid&&out_ready; in_ready rises the cycle after; no request is accepted in the same cycle.
REQ-029 SHALL ignore in_* inputs while not IDLE, with no effect on the in-flight operation.

Reset
REQ-030 SHALL, while reset_n=0, force state IDLE, counter 0, out_valid=0, busy=0, in_ready=1; datapath registers need no reset.
REQ-031 SHALL, when reset is asserted mid-BUSY or mid-DONE, discard the operation with no output; the first cycle after deassertion shows in_ready=1.

Verification (XLEN=32, NUM_LANES=4 unless stated)
REQ-032 SHALL cover: unsigned, all lanes 100/7, is_rem=0 -> out_valid exactly 33 cycles after fire, result 14; is_rem=1 -> 2.
REQ-033 SHALL cover: signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; lane with tmask=0 -> 0.
REQ-034 SHALL cover: all lanes 5/0 -> out_valid 1 cycle after fire, quotient 0xFFFFFFFF, remainder 5; with lane 2 normal (9/3) -> 33-cycle latency, lane 2 = 3.
REQ-035 SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-036 SHALL cover: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, a pulsed in_valid is ignored; on out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-037 SHALL cover: XLEN=64, is_w=1, unsigned 0xFFFFFFFF/1 -> latency 33, result 0xFFFFFFFFFFFFFFFF; reset_n pulsed mid-BUSY -> no out_valid, in_ready=1 after release.
